pipeline_hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipeline_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
//   It resolves load-use stalls, taken-branch flushes and multi-cycle data-memory
//   waits, and it latches a sticky fault when a data-memory access times out.
//
// Parameters
//   MEM_TIMEOUT  maximum number of MEM_WAIT cycles before FAULT (>= 1)
//   CNT_W        width of the saturating stall counter
//
// Ports
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   idex_memread, idex_rd       the instruction in EX is a load, and its destination
//   ifid_rs1, ifid_rs2          source registers of the instruction in ID
//   ex_pc_src                   branch or jump taken, resolved in EX
//   exmem_memop, dmem_ready     memory op in MEM; the memory completes this cycle
//   pc_en                       PC register enable
//   *_en / *_flush              pipeline register enable / load bubble
//                               (a flush wins over the matching enable)
//   dmem_req                    data-memory access request
//   fault                       sticky timeout fault
//   stall_cnt                   saturating count of cycles with pc_en low
//   state                       debug view of the FSM (RUN=0, MEM_WAIT=1, FAULT=2)
//
// Handshake: the memory access in MEM is held (dmem_req=1) until a cycle in which
// dmem_ready=1. That cycle completes the access, and the pipeline advances on the
// same clock edge.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ex_pc_src,
    input  logic             exmem_memop,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             dmem_req,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] FAULT    = 2'd2;

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(MEM_TIMEOUT);

    logic [1:0]      next_state;
    logic [WC_W-1:0] wait_cnt;
    logic            load_use;
    logic            advance;

    assign load_use = idex_memread && (idex_rd != 5'd0) &&
                      ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

    // The pipeline advances either in RUN when MEM is not blocked, or in the
    // MEM_WAIT cycle where the memory finally answers. In both cases the branch
    // and load-use rules then apply to whatever currently sits in EX and ID.
    assign advance = ((state == RUN) && !(exmem_memop && !dmem_ready)) ||
                     ((state == MEM_WAIT) && dmem_ready);

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        memwb_flush = 1'b0;
        dmem_req    = 1'b0;
        next_state  = state;

        case (state)
            RUN: begin
                dmem_req = exmem_memop;
                if (exmem_memop && !dmem_ready) begin
                    memwb_flush = 1'b1;
                    next_state  = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    next_state = RUN;
                end else begin
                    memwb_flush = 1'b1;
                    if (wait_cnt == WC_LIMIT) begin
                        next_state = FAULT;
                    end
                end
            end
            FAULT: begin
                memwb_flush = 1'b1;
            end
            default: begin
                next_state = RUN;
            end
        endcase

        if (advance) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            // A taken branch squashes the load's consumer, so load-use is moot.
            if (ex_pc_src) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end

        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_en     = 1'b0;
            idex_flush  = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            memwb_flush = 1'b0;
            dmem_req    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            fault     <= 1'b0;
        end else begin
            state <= next_state;
            if ((state == RUN) && (next_state == MEM_WAIT)) begin
                wait_cnt <= WC_W'(1);
            end else if ((state == MEM_WAIT) && (next_state == MEM_WAIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if ((state == MEM_WAIT) && (next_state == FAULT)) begin
                fault <= 1'b1;
            end
            if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    // Control vector bit order:
    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush, dmem_req, fault}
    localparam logic [9:0] V_RST = 10'b0000000000;
    localparam logic [9:0] V_RUN = 10'b1101011000;
    localparam logic [9:0] V_LU  = 10'b0001111000;
    localparam logic [9:0] V_BR  = 10'b1111111000;
    localparam logic [9:0] V_MS  = 10'b0000000110;
    localparam logic [9:0] V_FT  = 10'b0000000101;
    localparam logic [9:0] V_REQ = 10'b0000000010;

    localparam int W = 29;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       idex_memread = 1'b0;
    logic [4:0] idex_rd = 5'd0;
    logic [4:0] ifid_rs1 = 5'd0;
    logic [4:0] ifid_rs2 = 5'd0;
    logic       ex_pc_src = 1'b0;
    logic       exmem_memop = 1'b0;
    logic       dmem_ready = 1'b0;

    logic        pc_en_a, ifid_en_a, ifid_flush_a, idex_en_a, idex_flush_a;
    logic        exmem_en_a, memwb_en_a, memwb_flush_a, dmem_req_a, fault_a;
    logic [15:0] stall_cnt_a;
    logic [1:0]  state_a;

    logic        pc_en_b, ifid_en_b, ifid_flush_b, idex_en_b, idex_flush_b;
    logic        exmem_en_b, memwb_en_b, memwb_flush_b, dmem_req_b, fault_b;
    logic [2:0]  stall_cnt_b;
    logic [1:0]  state_b;

    // dut_a: short timeout; dut_b: default timeout with a 3-bit stall counter.
    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ex_pc_src(ex_pc_src), .exmem_memop(exmem_memop), .dmem_ready(dmem_ready),
        .pc_en(pc_en_a), .ifid_en(ifid_en_a), .ifid_flush(ifid_flush_a),
        .idex_en(idex_en_a), .idex_flush(idex_flush_a), .exmem_en(exmem_en_a),
        .memwb_en(memwb_en_a), .memwb_flush(memwb_flush_a), .dmem_req(dmem_req_a),
        .fault(fault_a), .stall_cnt(stall_cnt_a), .state(state_a)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ex_pc_src(ex_pc_src), .exmem_memop(exmem_memop), .dmem_ready(dmem_ready),
        .pc_en(pc_en_b), .ifid_en(ifid_en_b), .ifid_flush(ifid_flush_b),
        .idex_en(idex_en_b), .idex_flush(idex_flush_b), .exmem_en(exmem_en_b),
        .memwb_en(memwb_en_b), .memwb_flush(memwb_flush_b), .dmem_req(dmem_req_b),
        .fault(fault_b), .stall_cnt(stall_cnt_b), .state(state_b)
    );

    logic [9:0] obs_vec;
    assign obs_vec = {pc_en_a, ifid_en_a, ifid_flush_a, idex_en_a, idex_flush_a,
                      exmem_en_a, memwb_en_a, memwb_flush_a, dmem_req_a, fault_a};

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    logic [15:0]  exp_sa = '0;
    logic [2:0]   exp_sb = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge: drives one cycle of inputs, queues the
    // expected outputs, compares on the falling edge, then moves to the next cycle.
    task automatic step(input string tag, input logic rst_i, input logic memread_i,
                        input logic [4:0] rd_i, input logic [4:0] rs1_i, input logic [4:0] rs2_i,
                        input logic pc_src_i, input logic memop_i, input logic ready_i,
                        input logic [9:0] exp_vec);
        logic [W-1:0] e;
        reset        = rst_i;
        idex_memread = memread_i;
        idex_rd      = rd_i;
        ifid_rs1     = rs1_i;
        ifid_rs2     = rs2_i;
        ex_pc_src    = pc_src_i;
        exmem_memop  = memop_i;
        dmem_ready   = ready_i;
        if (rst_i) begin
            exp_sa = '0;
            exp_sb = '0;
        end
        exp_q.push_back({exp_vec, exp_sa, exp_sb});
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, ":ctl"},    32'(obs_vec),     32'(e[28:19]));
        check({tag, ":cnt_a"},  32'(stall_cnt_a), 32'(e[18:3]));
        check({tag, ":cnt_b"},  32'(stall_cnt_b), 32'(e[2:0]));
        if (!rst_i && !exp_vec[9]) begin
            if (exp_sa != 16'hFFFF) exp_sa = exp_sa + 16'd1;
            if (exp_sb != 3'd7)     exp_sb = exp_sb + 3'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held: everything low, counters clear
        step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, V_RST);
        step("rst1", 1, 0, 0, 0, 0, 0, 1, 0, V_RST);
        step("idle", 0, 0, 0, 0, 0, 0, 0, 0, V_RUN);

        // load-use on rs2, exactly one stall cycle
        step("lu_rs2",   0, 1, 5, 1, 5, 0, 0, 0, V_LU);
        step("lu_after", 0, 0, 5, 1, 5, 0, 0, 0, V_RUN);
        // load to x0 never stalls
        step("lu_x0",    0, 1, 0, 0, 0, 0, 0, 0, V_RUN);
        // taken branch overrides load-use
        step("br_lu",    0, 1, 7, 7, 3, 1, 0, 0, V_BR);
        // load-use on rs1
        step("lu_rs1",   0, 1, 9, 9, 3, 0, 0, 0, V_LU);
        // no load, no stall even with matching registers
        step("nolu",     0, 0, 9, 9, 9, 0, 0, 0, V_RUN);
        // memop ready the same cycle: no stall
        step("mem_hit",  0, 0, 0, 0, 0, 0, 1, 1, V_RUN | V_REQ);

        // memory wait of 3 cycles then resume
        step("mw_1",     0, 0, 0, 0, 0, 0, 1, 0, V_MS);
        step("mw_2",     0, 0, 0, 0, 0, 0, 1, 0, V_MS);
        step("mw_3",     0, 0, 0, 0, 0, 0, 1, 0, V_MS);
        step("mw_done",  0, 0, 0, 0, 0, 0, 1, 1, V_RUN | V_REQ);

        // branch deferred during the wait, applied on the completing cycle
        step("mwb_1",    0, 0, 0, 0, 0, 1, 1, 0, V_MS);
        step("mwb_2",    0, 0, 0, 0, 0, 1, 1, 0, V_MS);
        step("mwb_done", 0, 1, 4, 4, 0, 1, 1, 1, V_BR | V_REQ);

        // load-use applied on the completing cycle
        step("mwl_1",    0, 1, 4, 4, 0, 0, 1, 0, V_MS);
        step("mwl_done", 0, 1, 4, 4, 0, 0, 1, 1, V_LU | V_REQ);
        step("mwl_go",   0, 0, 4, 4, 0, 0, 0, 0, V_RUN);

        // timeout on dut_a (MEM_TIMEOUT=4): fault after 5 stalled cycles, sticky
        for (int i = 0; i < 5; i++) begin
            step("to_wait", 0, 0, 0, 0, 0, 0, 1, 0, V_MS);
        end
        step("to_fault", 0, 0, 0, 0, 0, 0, 0, 0, V_FT);
        step("to_hold",  0, 0, 0, 0, 0, 1, 0, 0, V_FT);

        // reset pulse out of FAULT, back to RUN
        step("to_rst",   1, 0, 0, 0, 0, 0, 0, 0, V_RST);
        check("state_rst", 32'(state_a), 32'd0);
        step("to_run",   0, 0, 0, 0, 0, 0, 0, 0, V_RUN);

        // saturation of dut_b's 3-bit counter over 10 stall cycles
        for (int i = 0; i < 10; i++) begin
            step("sat", 0, 0, 0, 0, 0, 0, 1, 0, (i < 5) ? V_MS : V_FT);
        end
        step("sat_end", 0, 0, 0, 0, 0, 0, 0, 0, V_FT);
        check("sat_b_hold", 32'(stall_cnt_b), 32'd7);
        check("q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
